// File: rtl/ipg_rx.sv
// ---------------------------------------------------------------------------
// ipg_rx - receive-side IPG message extractor.
//
// Sits between the 10GBASE-R RX interface (block-locked, descrambled 64b/66b
// blocks) and the XGMII decoder. In-band IPG messages are a marker block
// followed by one payload block. Both blocks are replaced by idle blocks on
// the way to the decoder. The 64-bit payload goes into a reply FIFO or a
// request FIFO, depending on the marker type. Both FIFOs are first-word
// fall-through (FWFT).
//
// Ports
//   clk, rst                 block clock; asynchronous active-high reset
//   encoded_rx_data/hdr      incoming block payload / sync header
//   rx_block_lock            extraction is enabled only while high
//   proced_encoded_rx_data/hdr  outgoing block, exactly one cycle later
//   ipg_reply_chunk, reply_valid, reply_ready   reply FIFO head / pop
//   ipg_req_chunk, req_valid, req_ready         request FIFO head / pop
//   msg_err                  pulse: a marker was not followed by a data block
//   reply_drop, req_drop     pulse: chunk lost because its FIFO was full
//   fsm_state                current extractor state (0 HUNT, 1 MARK_REP,
//                            2 MARK_REQ)
//
// Handshake: a FIFO entry is popped on any cycle where valid && ready are
// both high at the clock edge. The head output is meaningful only while
// valid is high. Valid never depends on ready.
// ---------------------------------------------------------------------------
module ipg_rx #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] encoded_rx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_rx_hdr,
    input  logic                  rx_block_lock,
    output logic [DATA_WIDTH-1:0] proced_encoded_rx_data,
    output logic [HDR_WIDTH-1:0]  proced_encoded_rx_hdr,
    output logic [DATA_WIDTH-1:0] ipg_reply_chunk,
    output logic                  reply_valid,
    input  logic                  reply_ready,
    output logic [DATA_WIDTH-1:0] ipg_req_chunk,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  msg_err,
    output logic                  reply_drop,
    output logic                  req_drop,
    output logic [1:0]            fsm_state
);

    localparam logic [DATA_WIDTH-1:0] IDLE_DATA = DATA_WIDTH'(64'h1E);
    localparam logic [HDR_WIDTH-1:0]  HDR_CTRL  = HDR_WIDTH'(2'b10);
    localparam logic [HDR_WIDTH-1:0]  HDR_DATA  = HDR_WIDTH'(2'b01);

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        MARK_REP = 2'd1,
        MARK_REQ = 2'd2
    } state_t;

    state_t state, state_n;

    logic is_rep_mark, is_req_mark, is_data;
    logic hunt_idle;
    state_t hunt_next;
    logic emit_idle, push_rep, push_req, err;
    logic rep_accept, req_accept;

    assign is_rep_mark = (encoded_rx_hdr == HDR_CTRL) && (encoded_rx_data[7:0] == 8'hA5);
    assign is_req_mark = (encoded_rx_hdr == HDR_CTRL) && (encoded_rx_data[7:0] == 8'h5A);
    assign is_data     = (encoded_rx_hdr == HDR_DATA);

    // What HUNT would do with the current block. The MARK_* error path reuses
    // this, so a marker that breaks a pending message starts a new message.
    always_comb begin
        hunt_next = HUNT;
        hunt_idle = 1'b0;
        if (is_rep_mark) begin
            hunt_next = MARK_REP;
            hunt_idle = 1'b1;
        end else if (is_req_mark) begin
            hunt_next = MARK_REQ;
            hunt_idle = 1'b1;
        end
    end

    // Without block lock the state falls back to HUNT and every block passes
    // through unchanged. Any pending marker is therefore dropped silently.
    always_comb begin
        state_n   = HUNT;
        emit_idle = 1'b0;
        push_rep  = 1'b0;
        push_req  = 1'b0;
        err       = 1'b0;
        if (rx_block_lock) begin
            case (state)
                HUNT: begin
                    state_n   = hunt_next;
                    emit_idle = hunt_idle;
                end
                MARK_REP, MARK_REQ: begin
                    if (is_data) begin
                        emit_idle = 1'b1;
                        push_rep  = (state == MARK_REP);
                        push_req  = (state == MARK_REQ);
                    end else begin
                        err       = 1'b1;
                        state_n   = hunt_next;
                        emit_idle = hunt_idle;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= HUNT;
            proced_encoded_rx_data <= IDLE_DATA;
            proced_encoded_rx_hdr  <= HDR_CTRL;
            msg_err                <= 1'b0;
            reply_drop             <= 1'b0;
            req_drop               <= 1'b0;
        end else begin
            state                  <= state_n;
            proced_encoded_rx_data <= emit_idle ? IDLE_DATA : encoded_rx_data;
            proced_encoded_rx_hdr  <= emit_idle ? HDR_CTRL  : encoded_rx_hdr;
            msg_err                <= err;
            reply_drop             <= push_rep && !rep_accept;
            req_drop               <= push_req && !req_accept;
        end
    end

    assign fsm_state = state;

    ipg_rx_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_reply_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_rep),
        .push_data (encoded_rx_data),
        .ready     (reply_ready),
        .head      (ipg_reply_chunk),
        .valid     (reply_valid),
        .accept    (rep_accept)
    );

    ipg_rx_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (encoded_rx_data),
        .ready     (req_ready),
        .head      (ipg_req_chunk),
        .valid     (req_valid),
        .accept    (req_accept)
    );

endmodule

// ---------------------------------------------------------------------------
// ipg_rx_fifo - small FWFT chunk FIFO.
//
// Ports
//   clk, rst    clock; asynchronous active-high reset (pointers to 0)
//   push        write request for push_data
//   push_data   entry to write
//   ready       pop request; takes effect only while valid is high
//   head        oldest entry; meaningful while valid is high
//   valid       FIFO is non-empty
//   accept      a push this cycle would be stored. This is true when there
//               is free space, or when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module ipg_rx_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             accept
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, count;
    logic             pop, wr_en;

    // The pointers carry one extra wrap bit. Their difference is the
    // occupancy, 0..DEPTH.
    assign count  = wr_ptr - rd_ptr;
    assign valid  = (count != '0);
    assign pop    = valid && ready;
    assign accept = (count < PTR_W'(DEPTH)) || pop;
    assign wr_en  = push && accept;
    assign head   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // When the FIFO is full, a push and a pop in the same cycle both address
    // the same slot. The head is read combinationally before the edge, so
    // overwriting that slot at the edge is safe.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: tb/tb_ipg_rx.sv
// ---------------------------------------------------------------------------
// tb_ipg_rx - directed self-checking bench for ipg_rx.
// Inputs are driven 1 time unit after a rising edge. Outputs are checked
// 1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_ipg_rx;

    localparam logic [63:0] IDLE = 64'h1E;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [63:0] encoded_rx_data = IDLE;
    logic [1:0]  encoded_rx_hdr  = 2'b10;
    logic        rx_block_lock   = 1'b1;
    logic        reply_ready     = 1'b0;
    logic        req_ready       = 1'b0;
    logic [63:0] proced_encoded_rx_data, ipg_reply_chunk, ipg_req_chunk;
    logic [1:0]  proced_encoded_rx_hdr, fsm_state;
    logic        reply_valid, req_valid, msg_err, reply_drop, req_drop;

    int n_checks = 0;
    int n_fail   = 0;

    logic [65:0] exp_q[$];
    logic [63:0] exp_v;

    ipg_rx #(.DATA_WIDTH(64), .HDR_WIDTH(2), .FIFO_DEPTH(4)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .encoded_rx_data        (encoded_rx_data),
        .encoded_rx_hdr         (encoded_rx_hdr),
        .rx_block_lock          (rx_block_lock),
        .proced_encoded_rx_data (proced_encoded_rx_data),
        .proced_encoded_rx_hdr  (proced_encoded_rx_hdr),
        .ipg_reply_chunk        (ipg_reply_chunk),
        .reply_valid            (reply_valid),
        .reply_ready            (reply_ready),
        .ipg_req_chunk          (ipg_req_chunk),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .msg_err                (msg_err),
        .reply_drop             (reply_drop),
        .req_drop               (req_drop),
        .fsm_state              (fsm_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver: present one block, then advance to just after the next edge
    task automatic send(input logic [1:0] h, input logic [63:0] d);
        encoded_rx_hdr  = h;
        encoded_rx_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_data"}, proced_encoded_rx_data, IDLE);
        check({tag, "_hdr"}, 64'(proced_encoded_rx_hdr), 64'(2'b10));
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_msg_err"}, 64'(msg_err), 64'd0);
        check({tag, "_reply_drop"}, 64'(reply_drop), 64'd0);
        check({tag, "_req_drop"}, 64'(req_drop), 64'd0);
    endtask

    // pass-through vectors: {hdr, data}
    logic [65:0] pt_vec [8] = '{
        {2'b10, 64'hD555_5555_5555_5578},
        {2'b01, 64'h1122_3344_5566_7788},
        {2'b10, 64'h0000_0000_0000_00FF},
        {2'b10, IDLE},
        {2'b01, 64'h0000_0000_0000_00A5},
        {2'b00, 64'h0123_4567_89AB_CDEF},
        {2'b11, 64'hFFFF_FFFF_FFFF_FF5A},
        {2'b10, IDLE}
    };

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_reply_valid", 64'(reply_valid), 64'd0);
        check("reset_req_valid", 64'(req_valid), 64'd0);
        check_pulses("reset");
        check("reset_state", 64'(fsm_state), 64'd0);
        rst = 1'b0;

        // reply message
        send(2'b10, 64'h1234_5678_9ABC_DEA5);
        check_idle("rep_marker");
        check("rep_state", 64'(fsm_state), 64'd1);
        check("rep_valid_early", 64'(reply_valid), 64'd0);
        send(2'b01, 64'hDEADBEEF_01234567);
        check_idle("rep_payload");
        check("rep_valid", 64'(reply_valid), 64'd1);
        check("rep_chunk", ipg_reply_chunk, 64'hDEADBEEF_01234567);
        check("rep_req_valid", 64'(req_valid), 64'd0);
        check_pulses("rep");
        reply_ready = 1'b1;
        send(2'b10, IDLE);
        reply_ready = 1'b0;
        check("rep_popped", 64'(reply_valid), 64'd0);

        // pass-through, checked against a delayed copy of the input
        foreach (pt_vec[i]) begin
            exp_q.push_back(pt_vec[i]);
            send(pt_vec[i][65:64], pt_vec[i][63:0]);
            check($sformatf("pass_%0d", i), {62'd0, proced_encoded_rx_hdr, proced_encoded_rx_data} >> 0 == 0 ? 64'd0 : proced_encoded_rx_data, exp_q[0][63:0]);
            check($sformatf("pass_hdr_%0d", i), 64'(proced_encoded_rx_hdr), 64'(exp_q[0][65:64]));
            void'(exp_q.pop_front());
            check_pulses($sformatf("pass_%0d", i));
            check($sformatf("pass_rvalid_%0d", i), 64'(reply_valid), 64'd0);
        end

        // broken marker: a request marker replaced by a reply marker
        send(2'b10, 64'h0000_0000_0000_005A);
        check_idle("brk_m1");
        send(2'b10, 64'h0000_0000_0000_00A5);
        check_idle("brk_m2");
        check("brk_err", 64'(msg_err), 64'd1);
        send(2'b01, 64'h55);
        check_idle("brk_payload");
        check("brk_err_once", 64'(msg_err), 64'd0);
        check("brk_rvalid", 64'(reply_valid), 64'd1);
        check("brk_chunk", ipg_reply_chunk, 64'h55);
        check("brk_qvalid", 64'(req_valid), 64'd0);
        reply_ready = 1'b1;
        send(2'b10, IDLE);
        reply_ready = 1'b0;
        check("brk_popped", 64'(reply_valid), 64'd0);

        // overflow: five replies with no pops
        for (int i = 0; i < 5; i++) begin
            send(2'b10, 64'hA5);
            send(2'b01, 64'hC0 + 64'(i));
            check_idle($sformatf("ovf_payload_%0d", i));
            check($sformatf("ovf_drop_%0d", i), 64'(reply_drop), (i == 4) ? 64'd1 : 64'd0);
        end
        check("ovf_head", ipg_reply_chunk, 64'hC0);
        send(2'b10, IDLE);
        check("ovf_drop_clear", 64'(reply_drop), 64'd0);
        // full FIFO: pop and push in the same cycle
        send(2'b10, 64'hA5);
        reply_ready = 1'b1;
        send(2'b01, 64'hC5);
        reply_ready = 1'b0;
        check("ovf_simul_drop", 64'(reply_drop), 64'd0);
        exp_q = '{66'h0C1, 66'h0C2, 66'h0C3, 66'h0C5};
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front()[63:0];
            check("ovf_drain_valid", 64'(reply_valid), 64'd1);
            check("ovf_drain_head", ipg_reply_chunk, exp_v);
            reply_ready = 1'b1;
            send(2'b10, IDLE);
            reply_ready = 1'b0;
        end
        check("ovf_empty", 64'(reply_valid), 64'd0);

        // lock loss during the payload cycle
        send(2'b10, 64'hA5);
        check_idle("lock_marker");
        rx_block_lock = 1'b0;
        send(2'b01, 64'hABCD);
        check("lock_pass_data", proced_encoded_rx_data, 64'hABCD);
        check("lock_pass_hdr", 64'(proced_encoded_rx_hdr), 64'(2'b01));
        check("lock_rvalid", 64'(reply_valid), 64'd0);
        check("lock_state", 64'(fsm_state), 64'd0);
        check_pulses("lock");
        send(2'b10, 64'hA5);
        check("unlock_marker_pass", proced_encoded_rx_data, 64'hA5);
        rx_block_lock = 1'b1;
        send(2'b10, 64'hA5);
        send(2'b01, 64'h77);
        check("relock_rvalid", 64'(reply_valid), 64'd1);
        check("relock_chunk", ipg_reply_chunk, 64'h77);

        // async reset between marker and payload, with an entry still queued
        send(2'b10, 64'h5A);
        check("ar_state", 64'(fsm_state), 64'd2);
        encoded_rx_hdr  = 2'b01;
        encoded_rx_data = 64'h99;
        #2 rst = 1'b1;
        #1;
        check_idle("ar_async");
        check("ar_rvalid", 64'(reply_valid), 64'd0);
        check("ar_state_rst", 64'(fsm_state), 64'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("ar_orphan_data", proced_encoded_rx_data, 64'h99);
        check("ar_orphan_hdr", 64'(proced_encoded_rx_hdr), 64'(2'b01));
        check("ar_qvalid", 64'(req_valid), 64'd0);
        check_pulses("ar");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ipg_rx.md
# ipg_rx

Receive-side IPG message extractor, the counterpart of the transmit-side IPG inserter. It sits between the 10GBASE-R RX interface (block-locked, descrambled 64b/66b blocks) and the XGMII 64b/66b decoder. It detects in-band IPG message blocks, removes them from the stream by substituting standard idle blocks, and queues the carried 64-bit reply/request chunks into two small FWFT FIFOs for the memory/request logic.

## Interface
- DATA_WIDTH, 64: block payload width; only 64 is supported.
- HDR_WIDTH, 2: sync header width; only 2 is supported.
- FIFO_DEPTH, 4: entries per chunk FIFO; power of two, ≥2.

- clk  in  1  block clock, one 66b block per cycle.
- rst  in  1  reset; one clock, asynchronous, active-high.
- encoded_rx_data  in  64  block payload from the RX interface.
- encoded_rx_hdr  in  2  sync header from the RX interface.
- rx_block_lock  in  1  block lock; extraction is enabled only while high.
- proced_encoded_rx_data  out  64  payload to the decoder, with IPG blocks replaced by idle.
- proced_encoded_rx_hdr  out  2  header to the decoder.
- ipg_reply_chunk  out  64  head of the reply FIFO.
- reply_valid  out  1  reply FIFO is non-empty.
- reply_ready  in  1  pops the reply FIFO when reply_valid is high.
- ipg_req_chunk  out  64  head of the request FIFO.
- req_valid  out  1  request FIFO is non-empty.
- req_ready  in  1  pops the request FIFO when req_valid is high.
- msg_err  out  1  one-cycle pulse: marker not followed by a data block.
- reply_drop  out  1  one-cycle pulse: reply chunk lost because the FIFO was full.
- req_drop  out  1  one-cycle pulse: request chunk lost because the FIFO was full.

## Operation
- Idle block (IDLE_BLK): hdr 2'b10, data 64'h0000_0000_0000_001E.
- Marker block: hdr 2'b10 with data[7:0] of 8'hA5 (reply) or 8'h5A (request). data[63:8] is don't-care.
- Payload block: the block immediately after a marker, hdr 2'b01. All 64 bits are the chunk.
- FSM states:
  - HUNT: reply marker goes to MARK_REP; request marker goes to MARK_REQ; any other block passes unchanged.
  - MARK_REP / MARK_REQ: the marker was already emitted as IDLE_BLK.
    - If the current block is hdr 2'b01: emit IDLE_BLK, push the chunk to the matching FIFO, return to HUNT.
    - Otherwise: pulse msg_err, then treat the current block exactly as HUNT would. It may be a new marker, which replaces the old one; any other block passes unchanged.
- Every marker is emitted as IDLE_BLK, including a marker that later errors.
- Invalid headers (2'b00 or 2'b11) in HUNT pass unchanged; in MARK_* they raise msg_err.
- When rx_block_lock is low:
  - the FSM is forced to HUNT and all blocks pass unchanged;
  - no pushes and no msg_err;
  - FIFO contents are retained.
  - If lock drops while in MARK_*, the pending marker is discarded silently.
- FIFOs:
  - Each FIFO is FWFT: the chunk output is the head entry whenever valid is high.
  - Pop occurs on valid && ready.
  - A push is accepted if count < FIFO_DEPTH, or if a pop happens in the same cycle.
  - A push refused for lack of space is discarded, pulses the matching drop signal, and still emits IDLE_BLK.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Count runs 0..FIFO_DEPTH.
  - The chunk output is don't-care while valid is low.

## Timing
- Data path latency is exactly 1 cycle, for every block, in every state.
- A block sampled at cycle N appears on proced_* at N+1.
- A payload sampled at cycle N:
  - is written into the FIFO at the N→N+1 edge;
  - valid rises at N+1 if the FIFO was empty;
  - msg_err, reply_drop and req_drop are registered and assert at N+1.
- Pop-to-valid-update latency is 1 cycle; the new head is visible at the next cycle.
- Reset values:
  - proced_encoded_rx_data = 64'h1E and proced_encoded_rx_hdr = 2'b10;
  - all valids and pulses are 0;
  - FSM is in HUNT; both FIFOs are empty with pointers at 0.
- Reset asserted mid-message discards the pending marker and all FIFO contents.

## Test plan
- Reply message: reply marker (hdr 10, 8'hA5) then payload 64'hDEADBEEF_01234567 (hdr 01), lock high.
  - proced shows two IDLE_BLK at N+1 and N+2.
  - reply_valid rises at N+2 with ipg_reply_chunk = 64'hDEADBEEF_01234567.
  - req_valid stays 0.
- Pass-through: a 3-block frame plus non-marker idles.
  - proced equals the input delayed by 1 cycle, bit-exact.
  - No pulses and no pushes.
- Broken marker: request marker followed by a reply marker, then payload 64'h55.
  - msg_err pulses once; 3 IDLE_BLK are emitted.
  - Reply FIFO gets 64'h55; request FIFO stays empty.
- Overflow: 5 reply messages with reply_ready = 0 and FIFO_DEPTH = 4.
  - 4 entries are stored; reply_drop pulses on the 5th payload.
  - The 5th payload block is still emitted as IDLE_BLK.
  - Full with a simultaneous pop and push: the push is accepted and count stays 4.
- Lock loss: reply marker, then rx_block_lock = 0 during the payload cycle.
  - The payload passes unchanged and no push occurs.
  - After relock, a fresh message extracts normally.
- Async reset: assert rst between marker and payload with no clock edge.
  - Outputs immediately show IDLE_BLK and valids 0.
  - After release, the orphan payload passes unchanged.
